ps2_scan_ctrl: RTL

Scan-code sequencing controller that sits directly behind the PS/2 byte receiver. It gates the receiver's enable, folds the multi-byte set-2 prefixes (E0 extended, F0 break) into single key events, filters line-error bytes, and buffers events in a small FIFO. The FIFO is drained by game logic through a valid/ready handshake. A watchdog discards a dangling prefix when a frame is lost.

---
 rtl/ps2_scan_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0 prefixes into single key events,
// drops line-error bytes, and queues events in a show-ahead FIFO with valid/ready drain.
module ps2_scan_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_i,
   output logic       rx_en_o,
   output logic       event_valid_o,
   input  logic       event_ready_i,
   output logic [7:0] event_code_o,
   output logic       event_ext_o,
   output logic       event_break_o,
   output logic       overflow_o,
   input  logic       overflow_clr_i
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [9:0]      mem_q [FIFO_DEPTH];

   logic       evt;
   logic [9:0] evt_data;
   logic       full, pop, push;
   logic [9:0] head;

   // Decoder: prefix bytes only move the state, error bytes abort, anything else is a key
   always_comb begin
      state_d  = state_q;
      evt      = 1'b0;
      evt_data = '0;
      if (rx_done_i) begin
         case (rx_data_i)
            8'hE0: begin
               if (state_q == S_IDLE) state_d = S_EXT;
            end
            8'hF0: begin
               if (state_q == S_IDLE)     state_d = S_BRK;
               else if (state_q == S_EXT) state_d = S_EXT_BRK;
            end
            8'h00, 8'hFF: state_d = S_IDLE;
            default: begin
               evt      = 1'b1;
               evt_data = {(state_q == S_EXT) || (state_q == S_EXT_BRK),
                           (state_q == S_BRK) || (state_q == S_EXT_BRK),
                           rx_data_i};
               state_d  = S_IDLE;
            end
         endcase
      end else if ((state_q != S_IDLE) && (wd_q == WD_MAX)) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      wd_d = wd_q + WD_W'(1);
      if (rx_done_i || (state_q == S_IDLE) || (wd_q == WD_MAX)) wd_d = '0;
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign full          = (count_q == FULL_CNT);
   assign event_valid_o = (count_q != '0);
   assign pop           = event_valid_o & event_ready_i;
   assign push          = evt & (~full | pop);
   assign rx_en_o       = ~full;

   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (evt && full && !pop) ovf_d = 1'b1;
      else if (overflow_clr_i) ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= S_IDLE;
         wd_q     <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= evt_data;
   end

   // Storage is not reset, so the head is masked whenever the FIFO is empty
   assign head          = event_valid_o ? mem_q[rd_ptr_q] : 10'd0;
   assign event_ext_o   = head[9];
   assign event_break_o = head[8];
   assign event_code_o  = head[7:0];
   assign overflow_o    = ovf_q;

endmodule
